axis_wdata: RTL
===============

AXIS_WDATA -- requirements
Module: axis_wdata

Interface
REQ-001 SHALL have parameter CONFIG_DWIDTH, default 32, width of the configuration length word.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one stream element.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 256, width of one AXI write data beat.
REQ-004 SHALL have parameter WIDTH_RATIO, default 8, elements per beat (AXI_DATA_WIDTH/DATA_WIDTH).
REQ-005 SHALL have parameter CONVERT_SHIFT, default 3, log2(WIDTH_RATIO).
REQ-006 SHALL have parameter AXI_LEN_WIDTH, default 8; beats per full burst = 2^AXI_LEN_WIDTH.
REQ-007 Ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-008 Ports: cfg_length  in  CONFIG_DWIDTH  element count; cfg_valid  in  1; cfg_ready  out  1.
REQ-009 Ports: data  in  DATA_WIDTH  stream element; data_valid  in  1; data_ready  out  1.
REQ-010 Ports: axi_wready  in  1; axi_wdata  out  AXI_DATA_WIDTH; axi_wstrb  out  AXI_DATA_WIDTH/8; axi_wlast  out  1; axi_wvalid  out  1.

Function
REQ-011 SHALL use one-hot states IDLE, ACTIVE, FLUSH, DONE.
REQ-012 IDLE: cfg_ready=1; cfg_valid -> latch element total = cfg_length and beat total = (cfg_length+WIDTH_RATIO-1)>>CONVERT_SHIFT; go ACTIVE, or DONE if cfg_length=0.
REQ-013 ACTIVE: data_ready=1 iff no beat pending, or pending beat accepted this cycle; element accepted on data_valid&data_ready.
REQ-014 Element k of a beat SHALL occupy axi_wdata[k*DATA_WIDTH +: DATA_WIDTH], k=0 first accepted (little-endian packing).
REQ-015 Beat SHALL become pending (axi_wvalid=1) the cycle after its WIDTH_RATIO-th element, or after the transfer's final element, is accepted.
REQ-016 Unfilled lanes of a final partial beat SHALL be zero.
REQ-017 Pending beat SHALL hold axi_wdata/axi_wstrb/axi_wlast stable until axi_wvalid&axi_wready.
REQ-018 axi_wlast SHALL be 1 on every 2^AXI_LEN_WIDTH-th beat (burst beat counter wraps to 0) and on the final beat of the transfer.
REQ-019 After final element accepted, data_ready=0 and state SHALL go FLUSH; FLUSH -> DONE when final beat accepted.
REQ-020 DONE SHALL last one cycle, then IDLE.
REQ-021 Element and beat counters SHALL be CONFIG_DWIDTH bits; no element beyond cfg_length SHALL be accepted.
REQ-022 cfg_valid outside IDLE SHALL be ignored.

Reset
REQ-023 rst SHALL force IDLE, clear all counters and pending beat; outputs: cfg_ready=1, data_ready=0, axi_wvalid=0, axi_wlast=0, axi_wdata=0, axi_wstrb=0.
REQ-024 rst mid-transfer SHALL discard partial beat and pending beat with no further axi_wvalid.

Configuration
REQ-025 Macro AXIS_WDATA_STRB_EN defined: axi_wstrb of a final partial beat SHALL enable only bytes of filled lanes; all other beats all ones.
REQ-026 Macro AXIS_WDATA_STRB_EN undefined: axi_wstrb SHALL be all ones on every beat (zero-padded lanes written).

Verification
REQ-027 cfg_length=8, 8 elements 1..8, wready=1 -> one beat, wdata lanes 0..7 = 1..8, wlast=1, wstrb=0xFFFFFFFF, DONE then cfg_ready=1.
REQ-028 cfg_length=20 with STRB_EN -> 3 beats; beat 3 lanes 0..3 = elements 17..20, lanes 4..7 = 0, wstrb=0x0000FFFF, wlast only on beat 3; without macro wstrb=0xFFFFFFFF.
REQ-029 cfg_length=2056 -> 257 beats; wlast=1 on beat 256 and beat 257 only.
REQ-030 wready=0 for 5 cycles with beat pending -> wdata/wlast stable, data_ready=0 after next beat fills; resumes without element loss.
REQ-031 cfg_length=0 -> no axi_wvalid, no data_ready, cfg_ready=1 again 2 cycles after acceptance.
REQ-032 rst asserted after 3 elements of cfg_length=16 -> axi_wvalid stays 0, next cfg_length=8 transfer yields correct single beat.

Source files
------------

// File: rtl/axis_wdata.sv
// -----------------------------------------------------------------------------
// axis_wdata
//
// Packs a stream of DATA_WIDTH elements into AXI write-data beats of
// AXI_DATA_WIDTH bits (WIDTH_RATIO elements per beat, little-endian lanes).
// A transfer is started by a configuration word giving the element count.
// The final beat may be partial; its unused lanes are zero. axi_wlast marks
// the end of every full burst of 2^AXI_LEN_WIDTH beats and the final beat.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cfg_length/cfg_valid/cfg_ready  transfer element count handshake
//   data/data_valid/data_ready      input element stream
//   axi_wdata/axi_wstrb/axi_wlast/axi_wvalid/axi_wready  AXI W channel
//
// Build option
//   AXIS_WDATA_STRB_EN  when defined, axi_wstrb of a final partial beat only
//                       enables the bytes of filled lanes; otherwise axi_wstrb
//                       is all ones on every beat (padding lanes are written).
// -----------------------------------------------------------------------------
module axis_wdata #(
    parameter int CONFIG_DWIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int WIDTH_RATIO    = 8,
    parameter int CONVERT_SHIFT  = 3,
    parameter int AXI_LEN_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic                        axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid
);

    localparam int STRB_W         = AXI_DATA_WIDTH / 8;
    localparam int LANE_W         = CONVERT_SHIFT;
    localparam int BYTES_PER_LANE = DATA_WIDTH / 8;

    localparam logic [3:0] IDLE   = 4'b0001;
    localparam logic [3:0] ACTIVE = 4'b0010;
    localparam logic [3:0] FLUSH  = 4'b0100;
    localparam logic [3:0] DONE   = 4'b1000;

    localparam logic [CONFIG_DWIDTH-1:0] CFG_ZERO  = {CONFIG_DWIDTH{1'b0}};
    localparam logic [CONFIG_DWIDTH-1:0] CFG_ONE   = CONFIG_DWIDTH'(1);
    localparam logic [LANE_W-1:0]        LANE_ZERO = {LANE_W{1'b0}};
    localparam logic [LANE_W-1:0]        LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0]        LANE_LAST = LANE_W'(WIDTH_RATIO - 1);
    localparam logic [AXI_LEN_WIDTH-1:0] BURST_ONE = AXI_LEN_WIDTH'(1);
    localparam logic [AXI_LEN_WIDTH-1:0] BURST_END = {AXI_LEN_WIDTH{1'b1}};

    // Control state
    logic [3:0]                state_r;
    logic [CONFIG_DWIDTH-1:0]  elem_total_r;
    logic [CONFIG_DWIDTH-1:0]  beat_total_r;
    logic [CONFIG_DWIDTH-1:0]  elem_cnt_r;
    logic [CONFIG_DWIDTH-1:0]  beat_cnt_r;
    logic [AXI_LEN_WIDTH-1:0]  burst_cnt_r;
    logic [LANE_W-1:0]         lane_r;
    logic [AXI_DATA_WIDTH-1:0] pack_r;

    // Output beat holding register
    logic [AXI_DATA_WIDTH-1:0] axi_wdata_r;
    logic [STRB_W-1:0]         axi_wstrb_r;
    logic                      axi_wlast_r;
    logic                      axi_wvalid_r;

    // Combinational helpers
    logic                      accept_s;
    logic                      pop_s;
    logic                      last_elem_s;
    logic                      beat_full_s;
    logic                      load_s;
    logic                      last_beat_s;
    logic                      cfg_take_s;
    logic [AXI_DATA_WIDTH-1:0] next_pack_s;
    logic [STRB_W-1:0]         beat_strb_s;
    logic [CONFIG_DWIDTH-1:0]  beat_total_s;

`ifdef AXIS_WDATA_STRB_EN
    // Byte enables covering lanes 0..last_lane of a beat.
    function automatic logic [STRB_W-1:0] lane_strb(input logic [LANE_W-1:0] last_lane);
        logic [STRB_W-1:0] strb;
        strb = {STRB_W{1'b0}};
        for (int b = 0; b < STRB_W; b++) begin
            strb[b] = (LANE_W'(b / BYTES_PER_LANE) <= last_lane);
        end
        return strb;
    endfunction

    // Full beats always end on the last lane, so this is all ones except for
    // a final partial beat.
    assign beat_strb_s = lane_strb(lane_r);
`else
    assign beat_strb_s = {STRB_W{1'b1}};
`endif

    // Beat count rounded up without widening the configuration word.
    assign beat_total_s = (cfg_length >> CONVERT_SHIFT)
                        + {{(CONFIG_DWIDTH-1){1'b0}}, |cfg_length[CONVERT_SHIFT-1:0]};

    assign cfg_ready  = (state_r == IDLE);
    // Must follow axi_wready in the same cycle so a draining beat can be
    // replaced without a bubble; the output slot is then free next cycle.
    assign data_ready = (state_r == ACTIVE) && (!axi_wvalid_r || axi_wready);

    assign axi_wdata  = axi_wdata_r;
    assign axi_wstrb  = axi_wstrb_r;
    assign axi_wlast  = axi_wlast_r;
    assign axi_wvalid = axi_wvalid_r;

    // Handshake decode and insertion of the incoming element into its lane.
    always_comb begin
        cfg_take_s  = (state_r == IDLE) && cfg_valid;
        accept_s    = data_valid && data_ready;
        pop_s       = axi_wvalid_r && axi_wready;
        last_elem_s = ((elem_cnt_r + CFG_ONE) == elem_total_r);
        beat_full_s = (lane_r == LANE_LAST);
        load_s      = accept_s && (beat_full_s || last_elem_s);
        last_beat_s = ((beat_cnt_r + CFG_ONE) == beat_total_r);
        next_pack_s = pack_r;
        next_pack_s[int'(lane_r) * DATA_WIDTH +: DATA_WIDTH] = data;
    end

    // Transfer FSM, element counting and beat assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            elem_total_r <= CFG_ZERO;
            beat_total_r <= CFG_ZERO;
            elem_cnt_r   <= CFG_ZERO;
            lane_r       <= LANE_ZERO;
            pack_r       <= {AXI_DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_valid) begin
                        elem_total_r <= cfg_length;
                        beat_total_r <= beat_total_s;
                        elem_cnt_r   <= CFG_ZERO;
                        lane_r       <= LANE_ZERO;
                        pack_r       <= {AXI_DATA_WIDTH{1'b0}};
                        state_r      <= (cfg_length == CFG_ZERO) ? DONE : ACTIVE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (accept_s) begin
                        elem_cnt_r <= elem_cnt_r + CFG_ONE;
                        if (beat_full_s || last_elem_s) begin
                            // Beat handed to the output register; start clean
                            // so padding lanes of a partial beat read zero.
                            lane_r <= LANE_ZERO;
                            pack_r <= {AXI_DATA_WIDTH{1'b0}};
                        end else begin
                            lane_r <= lane_r + LANE_ONE;
                            pack_r <= next_pack_s;
                        end
                        state_r <= last_elem_s ? FLUSH : ACTIVE;
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                FLUSH: begin
                    // Only the final beat can be pending here.
                    state_r <= pop_s ? DONE : FLUSH;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output beat register, beat counter and burst position.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_wdata_r  <= {AXI_DATA_WIDTH{1'b0}};
            axi_wstrb_r  <= {STRB_W{1'b0}};
            axi_wlast_r  <= 1'b0;
            axi_wvalid_r <= 1'b0;
            beat_cnt_r   <= CFG_ZERO;
            burst_cnt_r  <= {AXI_LEN_WIDTH{1'b0}};
        end else if (cfg_take_s) begin
            beat_cnt_r  <= CFG_ZERO;
            burst_cnt_r <= {AXI_LEN_WIDTH{1'b0}};
        end else if (load_s) begin
            // Loading wins over a same-cycle pop: the old beat leaves as the
            // new one arrives.
            axi_wdata_r  <= next_pack_s;
            axi_wstrb_r  <= beat_strb_s;
            axi_wlast_r  <= (burst_cnt_r == BURST_END) || last_beat_s;
            axi_wvalid_r <= 1'b1;
            beat_cnt_r   <= beat_cnt_r + CFG_ONE;
            burst_cnt_r  <= burst_cnt_r + BURST_ONE;
        end else if (pop_s) begin
            axi_wvalid_r <= 1'b0;
        end else begin
            axi_wvalid_r <= axi_wvalid_r;
        end
    end

endmodule
